lg_2_bist_ctrl: RTL and testbench
=================================

LG_2_BIST_CTRL -- requirements
Module: lg_2_bist_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, SHALL set the wait cycles between applying a vector and sampling outputs (legal range 1..15).
REQ-002 Parameter LAST_VEC, default 63, SHALL set the final vector index of the sweep (legal range 0..63).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-005 START  input  1  SHALL be a one-cycle test launch request, honoured only in IDLE or DONE.
REQ-006 Y1, Y2, Y3, Y4  input  1 each  SHALL be the NOR-gate block outputs under test.
REQ-007 A, B, C, D, E, G  output  1 each  SHALL drive the NOR-gate block inputs.
REQ-008 BUSY  output  1  SHALL be high while a sweep is in progress.
REQ-009 DONE  output  1  SHALL be high once a sweep has completed, until the next START or RST.
REQ-010 PASS  output  1  SHALL be high with DONE when zero mismatches were recorded.
REQ-011 FAIL_CNT  output  7  SHALL count vectors with any mismatch.
REQ-012 FIRST_FAIL  output  6  SHALL hold the index of the first mismatching vector.
REQ-013 FAIL_MASK  output  4  SHALL hold the sticky OR of per-output mismatches, bit0=Y1 .. bit3=Y4.

Function
REQ-014 States SHALL be IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-015 Vector index VEC (6 bits) SHALL map A=VEC[5], B=VEC[4], C=VEC[3], D=VEC[2], E=VEC[1], G=VEC[0].
REQ-016 A..G SHALL be 0 in IDLE; in DONE they SHALL hold the last vector applied; they SHALL remain stable from APPLY through CHECK of each vector.
REQ-017 Expected values: Y1=NOR(A,B), Y2=NOR(A,B,C), Y3=NOR(A,B,C,D), Y4=NOR(A,B,C,D,E); G SHALL be excluded from all expected functions.
REQ-018 START in IDLE or DONE SHALL clear VEC, FAIL_CNT, FIRST_FAIL, FAIL_MASK, DONE and PASS, then enter APPLY on the next cycle.
REQ-019 APPLY SHALL last 1 cycle; SETTLE SHALL last exactly SETTLE_CYC cycles; CHECK SHALL last 1 cycle (2+SETTLE_CYC cycles per vector).
REQ-020 In CHECK, on any mismatch: FAIL_CNT SHALL increment, FAIL_MASK SHALL OR in the per-output mismatch bits, and FIRST_FAIL SHALL load VEC only if FAIL_CNT was 0.
REQ-021 From CHECK, if VEC==LAST_VEC the FSM SHALL go to DONE; otherwise VEC SHALL increment and the FSM SHALL go to APPLY.
REQ-022 DONE SHALL assert DONE=1 and PASS=(FAIL_CNT==0) in the cycle after the final CHECK; BUSY SHALL be 0 in IDLE and DONE and 1 otherwise.
REQ-023 START while BUSY SHALL be ignored.
REQ-024 FAIL_CNT SHALL saturate at 127.

Reset
REQ-025 RST SHALL take priority over START and all state, including mid-sweep.
REQ-026 After RST: state IDLE, VEC=0, A..G=0, BUSY=0, DONE=0, PASS=0, FAIL_CNT=0, FIRST_FAIL=0, FAIL_MASK=0.

Configuration
REQ-027 Macro LG2_BIST_STOP_ON_FAIL_EN defined: a CHECK with a mismatch SHALL go directly to DONE, with VEC frozen at the failing index.
REQ-028 Macro LG2_BIST_STOP_ON_FAIL_EN undefined: the sweep SHALL always run to LAST_VEC regardless of mismatches.

Verification
REQ-029 Correct NOR model, defaults, START pulse -> BUSY for 256 cycles, then DONE=1, PASS=1, FAIL_CNT=0, FAIL_MASK=0.
REQ-030 Y3 stuck at 0 -> Y3 expected 1 only at VEC 0,1,2,3 (A..D=0); FAIL_CNT=4, FIRST_FAIL=0, FAIL_MASK=4'b0100, PASS=0.
REQ-031 Y1 inverted only when G=1, with the macro defined -> DONE after VEC=1 CHECK, FIRST_FAIL=1, FAIL_CNT=1, A..G=000001.
REQ-032 RST asserted at VEC=20 mid-SETTLE -> next cycle all outputs at reset values; a later START restarts from VEC=0.
REQ-033 START re-pulsed while BUSY at VEC=10 -> no effect, sweep continues; START in DONE -> counters clear and a new sweep begins.
REQ-034 SETTLE_CYC=1, LAST_VEC=7 -> DONE after 24 cycles, A..F sequence 000000..000111 observed.

Source files
------------

// File: rtl/lg_2_bist_ctrl.sv
// BIST sweep controller for a 4-output NOR-gate block: applies 64 vectors, records mismatches.
// Optional LG2_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module lg_2_bist_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int LAST_VEC   = 63
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Y1,
  input  logic       Y2,
  input  logic       Y3,
  input  logic       Y4,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       G,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [6:0] FAIL_CNT,
  output logic [5:0] FIRST_FAIL,
  output logic [3:0] FAIL_MASK
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST        = 6'(LAST_VEC);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] vec;
  logic [3:0] settle_cnt;
  logic [3:0] exp_y;
  logic [3:0] obs_y;
  logic [3:0] mism;
  logic       any_mism;
  logic       stop_now;
  logic       launch;

  // Expected responses; G deliberately feeds none of them.
  assign exp_y[0] = ~|vec[5:4];
  assign exp_y[1] = ~|vec[5:3];
  assign exp_y[2] = ~|vec[5:2];
  assign exp_y[3] = ~|vec[5:1];
  assign obs_y    = {Y4, Y3, Y2, Y1};
  assign mism     = exp_y ^ obs_y;
  assign any_mism = |mism;
  assign launch   = START && ((state == S_IDLE) || (state == S_DONE));

`ifdef LG2_BIST_STOP_ON_FAIL_EN
  assign stop_now = any_mism;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (START) state_nxt = S_APPLY;
      S_APPLY:        state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (stop_now || (vec == LAST)) ? S_DONE : S_APPLY;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vec        <= '0;
      settle_cnt <= '0;
      FAIL_CNT   <= '0;
      FIRST_FAIL <= '0;
      FAIL_MASK  <= '0;
    end else if (launch) begin
      vec        <= '0;
      settle_cnt <= '0;
      FAIL_CNT   <= '0;
      FIRST_FAIL <= '0;
      FAIL_MASK  <= '0;
    end else begin
      case (state)
        S_APPLY:  settle_cnt <= '0;
        S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        S_CHECK: begin
          if (any_mism) begin
            if (FAIL_CNT != 7'd127) FAIL_CNT <= FAIL_CNT + 7'd1;
            if (FAIL_CNT == 7'd0)   FIRST_FAIL <= vec;
            FAIL_MASK <= FAIL_MASK | mism;
          end
          if (state_nxt == S_APPLY) vec <= vec + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // In DONE the vector register still holds the last vector applied.
  assign {A, B, C, D, E, G} = (state == S_IDLE) ? 6'd0 : vec;
  assign BUSY = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
  assign DONE = (state == S_DONE);
  assign PASS = DONE && (FAIL_CNT == 7'd0);

endmodule

// File: tb/tb_lg_2_bist_ctrl.sv
// Bench for lg_2_bist_ctrl: fault-injecting NOR block model plus sweep-level reference.
module tb_lg_2_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start0, start1;
  logic       y10, y20, y30, y40;
  logic       y11, y21, y31, y41;
  logic       a0, b0, c0, d0, e0, g0;
  logic       a1, b1, c1, d1, e1, g1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [6:0] fcnt0, fcnt1;
  logic [5:0] ffirst0, ffirst1;
  logic [3:0] fmask0, fmask1;
  logic [5:0] v0, v1;
  logic [3:0] xmask [64];

  int ncmp = 0;
  int nfail = 0;

  lg_2_bist_ctrl u_dut0 (
    .CLK(clk), .RST(rst), .START(start0),
    .Y1(y10), .Y2(y20), .Y3(y30), .Y4(y40),
    .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .G(g0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .FAIL_CNT(fcnt0), .FIRST_FAIL(ffirst0), .FAIL_MASK(fmask0)
  );

  lg_2_bist_ctrl #(.SETTLE_CYC(1), .LAST_VEC(7)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1),
    .Y1(y11), .Y2(y21), .Y3(y31), .Y4(y41),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .G(g1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .FAIL_CNT(fcnt1), .FIRST_FAIL(ffirst1), .FAIL_MASK(fmask1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Good-gate response by arithmetic: an output is 1 while its inputs (the top bits) are all zero.
  function automatic logic [3:0] nor_ref(input logic [5:0] v);
    nor_ref = {v < 6'd2, v < 6'd4, v < 6'd8, v < 6'd16};
  endfunction

  assign v0 = {a0, b0, c0, d0, e0, g0};
  assign v1 = {a1, b1, c1, d1, e1, g1};
  assign {y40, y30, y20, y10} = nor_ref(v0) ^ xmask[v0];
  assign {y41, y31, y21, y11} = nor_ref(v1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every vector whose injected fault mask is nonzero is a failing vector.
  task automatic model(input int last, input int settle, output int cnt, output int first,
                       output int fm, output int lastv, output int busy);
    cnt = 0; first = 0; fm = 0; lastv = last;
    for (int v = 0; v <= last; v++) begin
      if (xmask[v] != 4'd0) begin
        if (cnt == 0) first = v;
        if (cnt < 127) cnt++;
        fm = fm | int'(xmask[v]);
`ifdef LG2_BIST_STOP_ON_FAIL_EN
        lastv = v;
        break;
`endif
      end
    end
    busy = (lastv + 1) * (2 + settle);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_vec"}, 32'(v0), 0);
    chk({tag, "_busy"}, 32'(busy0), 0);
    chk({tag, "_done"}, 32'(done0), 0);
    chk({tag, "_pass"}, 32'(pass0), 0);
    chk({tag, "_cnt"}, 32'(fcnt0), 0);
    chk({tag, "_first"}, 32'(ffirst0), 0);
    chk({tag, "_mask"}, 32'(fmask0), 0);
  endtask

  task automatic run_sweep(input string tag, input bit restart);
    int m_cnt, m_first, m_fm, m_last, m_busy, k;
    model(63, 2, m_cnt, m_first, m_fm, m_last, m_busy);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk({tag, "_clr_cnt"}, 32'(fcnt0), 0);
    chk({tag, "_clr_mask"}, 32'(fmask0), 0);
    chk({tag, "_clr_done"}, 32'(done0), 0);
    k = 0;
    while (busy0 && k < 2000) begin
      chk({tag, "_vecseq"}, 32'(v0), 32'(k / 4));
      start0 = restart && (k == 41);
      k++;
      @(negedge clk);
    end
    start0 = 1'b0;
    chk({tag, "_busycyc"}, 32'(k), 32'(m_busy));
    chk({tag, "_done"}, 32'(done0), 1);
    chk({tag, "_pass"}, 32'(pass0), 32'(m_cnt == 0));
    chk({tag, "_cnt"}, 32'(fcnt0), 32'(m_cnt));
    chk({tag, "_first"}, 32'(ffirst0), 32'(m_first));
    chk({tag, "_mask"}, 32'(fmask0), 32'(m_fm));
    chk({tag, "_lastvec"}, 32'(v0), 32'(m_last));
    @(negedge clk);
    chk({tag, "_hold"}, 32'(v0), 32'(m_last));
  endtask

  initial begin
    int k;
    for (int v = 0; v < 64; v++) xmask[v] = 4'd0;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    chk("reset_dut1_busy", 32'(busy1), 0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep("clean", 1'b0);

    // Y3 stuck at 0: only visible where Y3 should be 1.
    for (int v = 0; v < 64; v++) xmask[v] = nor_ref(6'(v)) & 4'b0100;
    run_sweep("y3sa0", 1'b0);
`ifndef LG2_BIST_STOP_ON_FAIL_EN
    chk("y3sa0_cnt4", 32'(fcnt0), 4);
    chk("y3sa0_mask0100", 32'(fmask0), 4'b0100);
`endif

    // Y1 inverted whenever G=1.
    for (int v = 0; v < 64; v++) xmask[v] = {3'b000, 1'(v % 2)};
    run_sweep("y1g", 1'b0);
    chk("y1g_first1", 32'(ffirst0), 1);

    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 64; v++)
        xmask[v] = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      run_sweep($sformatf("rand%0d", r), 1'b0);
    end

    // START while busy is ignored; START in DONE relaunches with counters cleared.
    for (int v = 0; v < 64; v++) xmask[v] = 4'd0;
    run_sweep("restart_busy", 1'b1);
    run_sweep("restart_done", 1'b0);

    // Reset mid-SETTLE at vector 20.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (v0 != 6'd20 && k < 200) begin
      k++;
      @(negedge clk);
    end
    chk("rst_mid_reach20", 32'(v0), 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    run_sweep("after_rst", 1'b0);

    // Short configuration: SETTLE_CYC=1, LAST_VEC=7.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (busy1 && k < 200) begin
      chk("small_vecseq", 32'(v1), 32'(k / 3));
      k++;
      @(negedge clk);
    end
    chk("small_busycyc", 32'(k), 24);
    chk("small_done", 32'(done1), 1);
    chk("small_pass", 32'(pass1), 1);
    chk("small_cnt", 32'(fcnt1), 0);
    chk("small_first", 32'(ffirst1), 0);
    chk("small_mask", 32'(fmask1), 0);
    chk("small_lastvec", 32'(v1), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
